jk_sync_tx: RTL and testbench
=============================

# jk_sync_tx

- Transmit end of the J/K differential link whose receiver produces `synced_d`/`sync_err_d`.
- Function: accepts bytes over a valid/ready handshake and drives the `k`/`j`/`tx_en` lines with a sync pattern, NRZI-coded payload bits and an end-of-packet sequence.
- Placement: sits in front of the receiver under test, either in loopback benches or as the mission-mode source feeding the BIST input mux.

## Interface
- `SYNC_BYTE`, default 8'h80: sync byte, NRZI-coded LSB first from line state J; the default yields K J K J K J K K.
- `EOP_SE0_CYCLES`, default 2: number of SE0 cycles in EOP; legal range 1–7.
- `CLK` input 1: single clock, rising edge.
- `RST` input 1: asynchronous, active-low reset.
- `tx_valid` input 1: byte available.
- `tx_data` input 8: byte to send, LSB first.
- `tx_last` input 1: marks the final byte of a packet; sampled with the byte.
- `tx_ready` output 1: block accepts `tx_data` this cycle. Combinational from state.
- `k` output 1: K line.
- `j` output 1: J line.
- `tx_en` output 1: transmitter driving the lines.
- `busy` output 1: FSM not in IDLE.
- `done` output 1: one-cycle pulse on the final J cycle of a packet.
- `underrun_err` output 1: sticky flag. Set on data starvation; cleared on the next packet start.

## Operation
- **Symbols** (`tx_en`=1):
  - J: `j`=1, `k`=0.
  - K: `k`=1, `j`=0.
  - SE0: both 0.
  - Idle (`tx_en`=0): both 0.
- **NRZI:** internal `line` register, reset to J. A bit of 0 toggles `line`; a bit of 1 holds it. One bit is emitted per cycle.
- **States:** IDLE, SYNC, DATA, STUFF, EOP, EOPJ.
- **IDLE**
  - `tx_ready`=1.
  - On `tx_valid`&&`tx_ready`: latch byte and `tx_last`, clear `underrun_err`, set `line`=J and ones count=0, then go to SYNC.
- **SYNC:** 8 cycles, emitting `SYNC_BYTE` bits 0..7, then go to DATA with bit index 0.
- **DATA:** emits the latched byte bit `[idx]`, one bit per cycle.
- **Byte boundary** (`tx_ready`=1 only when idx=7, no stuff pending and latched last=0). At idx=7:
  - last=1: go to EOP.
  - else `tx_valid`=1: load the next byte, idx=0, stay in DATA.
  - else (`tx_valid`=0): set `underrun_err`=1 and go to EOP.
- **STUFF:** one cycle forced 0 (toggle), inserted after 6 consecutive 1 bits. The ones count includes sync bits. Afterwards resume DATA at the held idx, or take the idx=7 decision above.
- **EOP:** `EOP_SE0_CYCLES` SE0 cycles, then EOPJ.
- **EOPJ:** one cycle of J with `done`=1, then IDLE.
- **Reset:** asynchronous; applies immediately, also mid-packet.
  - All outputs 0 (`tx_ready` reads 1 once IDLE is restored).
  - `line`=J; counters cleared.
  - No EOP is sent.

## Timing
- Accept at edge T. First sync symbol appears from edge T to T+1. `tx_en` is high from T through EOPJ.
- Packet length in cycles = 8 + 8·N + stuff bits + `EOP_SE0_CYCLES` + 1.
- Next-byte accept occurs at the edge that ends the idx=7 bit. Continuous streaming gives no gap cycles.
- A stuff bit due at idx=7 is emitted before `tx_ready` rises (ready deferred one cycle).
- `done` and the EOPJ state coincide. `tx_valid` during EOP/EOPJ is ignored; a new packet is accepted no earlier than the IDLE cycle after EOPJ.
- All outputs except `tx_ready` are registered.

## Configuration
- `JK_BIT_STUFF_EN` defined: STUFF state and ones counter are compiled in, behaving as above.
- Undefined: no stuffing is performed; packet length = 8 + 8·N + `EOP_SE0_CYCLES` + 1.

## Test plan
- **Reset state:** hold `RST`=0 → `k`=`j`=`tx_en`=`busy`=`done`=`underrun_err`=0 and `tx_ready`=1. Release, then idle 5 cycles → no change.
- **Single byte 8'h00 with `tx_last`=1:**
  - Lines are KJKJKJKK, then JKJKJKJK, then SE0, SE0, J (`done`=1).
  - 19 `tx_en` cycles; IDLE on cycle 20.
- **Single byte 8'hFF with `tx_last`=1:**
  - With `JK_BIT_STUFF_EN`: data field K K K K K, J (stuff), J J J → 20 total cycles.
  - Without the macro: 8 × K → 19 cycles.
- **Two bytes 8'hA5, 8'h3C:** second byte's `tx_valid` held from the start → accepted exactly at the idx=7 edge; no gap; 27 cycles (no stuffing triggered).
- **Underrun:** byte 8'h12 with `tx_last`=0, then `tx_valid`=0 → `underrun_err`=1 after the idx=7 edge, EOP follows, `done` pulses. The next accepted packet clears `underrun_err`.
- **Reset mid-packet:** assert `RST` during DATA idx=3 → outputs 0 asynchronously. After release, a new 8'h00 packet starts with sync from line J.

Source files
------------

// File: rtl/jk_sync_tx.sv
// J/K differential link transmitter: sync pattern, NRZI payload (LSB first) and SE0/J end-of-packet.
// Define JK_BIT_STUFF_EN to insert a stuff bit after six consecutive ones; otherwise no stuffing.
module jk_sync_tx #(
    parameter logic [7:0] SYNC_BYTE      = 8'h80,
    parameter int         EOP_SE0_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       k,
    output logic       j,
    output logic       tx_en,
    output logic       busy,
    output logic       done,
    output logic       underrun_err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SYNC  = 3'd1,
        DATA  = 3'd2,
        STUFF = 3'd3,
        EOP   = 3'd4,
        EOPJ  = 3'd5
    } state_t;

    localparam logic [2:0] EOP_N = 3'(EOP_SE0_CYCLES);

    state_t     state_reg;
    logic [2:0] idx_reg;
    logic [2:0] eop_cnt_reg;
    logic [7:0] data_reg;
    logic       last_reg;
    logic       line_reg;
    logic       k_reg;
    logic       j_reg;
    logic       tx_en_reg;
    logic       busy_reg;
    logic       done_reg;
    logic       underrun_reg;

    logic       stuff_pending;
    logic       bit_next;
    logic       line_base;
    logic       line_next;
    logic       emit;
    logic [2:0] idx_inc;

    assign idx_inc = idx_reg + 3'd1;

`ifdef JK_BIT_STUFF_EN
    logic [2:0] ones_reg;
    logic [2:0] ones_next;

    // ones_reg counts the run of ones including the bit currently on the line
    assign stuff_pending = (state_reg == DATA) && (ones_reg >= 3'd6);

    always_comb begin
        ones_next = 3'd0;
        if (bit_next) begin
            if (state_reg == IDLE)
                ones_next = 3'd1;
            else if (ones_reg == 3'd7)
                ones_next = 3'd7;
            else
                ones_next = ones_reg + 3'd1;
        end
    end
`else
    assign stuff_pending = 1'b0;
`endif

    always_comb begin
        tx_ready = 1'b0;
        case (state_reg)
            IDLE:    tx_ready = 1'b1;
            DATA:    tx_ready = (idx_reg == 3'd7) && !last_reg && !stuff_pending;
            STUFF:   tx_ready = (idx_reg == 3'd7) && !last_reg;
            default: tx_ready = 1'b0;
        endcase
    end

    // Bit that will be on the line after the coming edge, and whether one is emitted at all
    always_comb begin
        bit_next = 1'b0;
        emit     = 1'b0;
        case (state_reg)
            IDLE: begin
                bit_next = SYNC_BYTE[0];
                emit     = tx_valid;
            end
            SYNC: begin
                bit_next = (idx_reg == 3'd7) ? data_reg[0] : SYNC_BYTE[idx_inc];
                emit     = 1'b1;
            end
            DATA, STUFF: begin
                if (stuff_pending) begin
                    bit_next = 1'b0;
                    emit     = 1'b1;
                end else if (idx_reg != 3'd7) begin
                    bit_next = data_reg[idx_inc];
                    emit     = 1'b1;
                end else begin
                    bit_next = tx_data[0];
                    emit     = !last_reg && tx_valid;
                end
            end
            default: begin
                bit_next = 1'b0;
                emit     = 1'b0;
            end
        endcase
        line_base = (state_reg == IDLE) ? 1'b1 : line_reg;
        line_next = bit_next ? line_base : ~line_base;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            idx_reg      <= 3'd0;
            eop_cnt_reg  <= 3'd0;
            data_reg     <= 8'd0;
            last_reg     <= 1'b0;
            line_reg     <= 1'b1;
            k_reg        <= 1'b0;
            j_reg        <= 1'b0;
            tx_en_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            underrun_reg <= 1'b0;
`ifdef JK_BIT_STUFF_EN
            ones_reg     <= 3'd0;
`endif
        end else begin
            done_reg <= 1'b0;

            if (emit) begin
                line_reg <= line_next;
                j_reg    <= line_next;
                k_reg    <= ~line_next;
`ifdef JK_BIT_STUFF_EN
                ones_reg <= ones_next;
`endif
            end

            case (state_reg)
                IDLE: begin
                    if (tx_valid) begin
                        data_reg     <= tx_data;
                        last_reg     <= tx_last;
                        underrun_reg <= 1'b0;
                        idx_reg      <= 3'd0;
                        tx_en_reg    <= 1'b1;
                        busy_reg     <= 1'b1;
                        state_reg    <= SYNC;
                    end
                end
                SYNC: begin
                    if (idx_reg == 3'd7) begin
                        idx_reg   <= 3'd0;
                        state_reg <= DATA;
                    end else begin
                        idx_reg <= idx_inc;
                    end
                end
                DATA, STUFF: begin
                    if (stuff_pending) begin
                        state_reg <= STUFF;
                    end else if (idx_reg != 3'd7) begin
                        idx_reg   <= idx_inc;
                        state_reg <= DATA;
                    end else if (!last_reg && tx_valid) begin
                        data_reg  <= tx_data;
                        last_reg  <= tx_last;
                        idx_reg   <= 3'd0;
                        state_reg <= DATA;
                    end else begin
                        // Either the packet ended or the source starved mid-packet
                        underrun_reg <= underrun_reg | ~last_reg;
                        eop_cnt_reg  <= 3'd1;
                        k_reg        <= 1'b0;
                        j_reg        <= 1'b0;
                        state_reg    <= EOP;
                    end
                end
                EOP: begin
                    if (eop_cnt_reg == EOP_N) begin
                        j_reg     <= 1'b1;
                        k_reg     <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= EOPJ;
                    end else begin
                        eop_cnt_reg <= eop_cnt_reg + 3'd1;
                    end
                end
                EOPJ: begin
                    j_reg     <= 1'b0;
                    k_reg     <= 1'b0;
                    tx_en_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign k            = k_reg;
    assign j            = j_reg;
    assign tx_en        = tx_en_reg;
    assign busy         = busy_reg;
    assign done         = done_reg;
    assign underrun_err = underrun_reg;

endmodule

// File: tb/tb_jk_sync_tx.sv
// Bench for jk_sync_tx: a bit-list model (sync, stuffing, NRZI, EOP) predicts every line cycle,
// and hand-written symbol strings pin the model for a few packets.
module tb_jk_sync_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_last = 1'b0;
    logic       tx_ready;
    logic       k;
    logic       j;
    logic       tx_en;
    logic       busy;
    logic       done;
    logic       underrun_err;

    jk_sync_tx dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_last      (tx_last),
        .tx_ready     (tx_ready),
        .k            (k),
        .j            (j),
        .tx_en        (tx_en),
        .busy         (busy),
        .done         (done),
        .underrun_err (underrun_err)
    );

    always #5 clk = ~clk;

    localparam logic [7:0] SYNC_PAT = 8'h80;
    localparam int         NSE0     = 2;

    int         errors = 0;
    int         checks = 0;
    logic [6:0] exp_q[$];
    bit         idle_chk = 1'b0;
    logic       exp_uerr_idle = 1'b0;
    string      cap = "";
    int         pkt_rdy = -1;

    function automatic string symch(input logic en, input logic kk, input logic jj);
        if (!en)            return "-";
        if (kk && !jj)      return "K";
        if (jj && !kk)      return "J";
        if (!jj && !kk)     return "0";
        return "X";
    endfunction

    // Vector order: tx_en k j busy done tx_ready underrun_err
    always @(negedge clk) begin
        logic [6:0] got;
        logic [6:0] e;
        got = {tx_en, k, j, busy, done, tx_ready, underrun_err};
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL line_cycle t=%0t got=%b required=%b (en k j busy done rdy uerr)", $time, got, e);
            end
            cap = {cap, symch(tx_en, k, j)};
        end else if (idle_chk) begin
            e = {5'b00000, 1'b1, exp_uerr_idle};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL idle_state t=%0t got=%b required=%b (en k j busy done rdy uerr)", $time, got, e);
            end
        end
    end

    task automatic chk_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d required=%0d", name, got, want);
        end
    endtask

    task automatic chk_str(input string name, input string got, input string want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%s required=%s", name, got, want);
        end
    endtask

    // Build the bit stream, stuff it, NRZI-code it from J and append the EOP
    task automatic build(input logic [7:0] b0, input logic [7:0] b1, input int nb,
                         input bit starve, output int rdy_idx);
        bit         bits[$];
        bit         rdy[$];
        int         run;
        logic       line;
        logic [7:0] cur;
        logic [7:0] sb;
        sb      = SYNC_PAT;
        run     = 0;
        rdy_idx = -1;
        for (int i = 0; i < 8; i++) begin
            bits.push_back(sb[i]);
            rdy.push_back(1'b0);
            run = sb[i] ? run + 1 : 0;
        end
        for (int n = 0; n < nb; n++) begin
            cur = (n == 0) ? b0 : b1;
            for (int i = 0; i < 8; i++) begin
                bits.push_back(cur[i]);
                rdy.push_back(1'b0);
                run = cur[i] ? run + 1 : 0;
`ifdef JK_BIT_STUFF_EN
                if (run == 6) begin
                    bits.push_back(1'b0);
                    rdy.push_back(1'b0);
                    run = 0;
                end
`endif
            end
            if (n < nb - 1 || starve)
                rdy[rdy.size() - 1] = 1'b1;
        end
        line = 1'b1;
        for (int i = 0; i < bits.size(); i++) begin
            if (!bits[i]) line = ~line;
            if (rdy[i]) rdy_idx = i;
            exp_q.push_back({1'b1, ~line, line, 1'b1, 1'b0, rdy[i], 1'b0});
        end
        for (int i = 0; i < NSE0; i++)
            exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, starve});
        exp_q.push_back({1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, starve});
        exp_uerr_idle = starve;
    endtask

    task automatic send(input logic [7:0] b0, input logic [7:0] b1, input int nb, input bit starve);
        int ri;
        int guard;
        tx_data  = b0;
        tx_last  = (nb == 1) && !starve;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        cap = "";
        build(b0, b1, nb, starve, ri);
        pkt_rdy = ri;
        if (nb == 2) begin
            tx_data = b1;
            tx_last = 1'b1;
            repeat (ri + 1) @(posedge clk);
            #1;
        end
        tx_valid = 1'b0;
        guard = 0;
        while (exp_q.size() > 0 && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL packet_timeout pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
        #1;
    endtask

    initial begin
        idle_chk      = 1'b1;
        exp_uerr_idle = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        send(8'h00, 8'h00, 1, 1'b0);
        chk_str("syms_00", cap, "KJKJKJKKJKJKJKJK00J");
        chk_int("len_00", cap.len(), 19);

        send(8'hFF, 8'h00, 1, 1'b0);
`ifdef JK_BIT_STUFF_EN
        chk_str("syms_ff", cap, "KJKJKJKKKKKKKJJJJ00J");
        chk_int("len_ff", cap.len(), 20);
`else
        chk_str("syms_ff", cap, "KJKJKJKKKKKKKKKK00J");
        chk_int("len_ff", cap.len(), 19);
`endif

        send(8'hA5, 8'h3C, 2, 1'b0);
        chk_int("ready_cycle_2b", pkt_rdy, 15);
        chk_int("len_2b", cap.len(), 27);

        send(8'h12, 8'h00, 1, 1'b1);
        chk_str("syms_underrun", cap, "KJKJKJKKJJKJJKJK00J");
        chk_int("uerr_set", int'(underrun_err), 1);

        send(8'h00, 8'h00, 1, 1'b0);
        chk_int("uerr_clr", int'(underrun_err), 0);

        // Reset asserted while data bit 3 is on the line
        tx_data  = 8'h00;
        tx_last  = 1'b1;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        cap = "";
        build(8'h00, 8'h00, 1, 1'b0, pkt_rdy);
        repeat (11) @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        exp_uerr_idle = 1'b0;
        #1;
        chk_int("async_reset_outs", int'({tx_en, k, j, busy, done, tx_ready, underrun_err}), 2);
        chk_str("pre_reset_syms", cap, "KJKJKJKKJKJ");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(8'h00, 8'h00, 1, 1'b0);
        chk_str("syms_after_reset", cap, "KJKJKJKKJKJKJKJK00J");

        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
